// File: rtl/alu_seq_bcd.sv
// alu_seq_bcd: WIDTH-bit handshaked ALU with registered result/flags and tri-state adl/sb drivers.
// Optional macro ALU_BCD_EN builds the nibble-serial decimal ADD/SUB sequencer; without it dec is ignored.
module alu_seq_bcd #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             dec,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             adl_oe,
  input  logic             sb_oe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] adl,
  output logic [WIDTH-1:0] sb,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             neg
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CNTW    = $clog2(NIBBLES);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_EOR = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_LSR = 3'd5;
  localparam logic [2:0] OP_ROR = 3'd6;
  localparam logic [2:0] OP_ROL = 3'd7;

`ifdef ALU_BCD_EN
  typedef enum logic [1:0] {S_IDLE, S_BCD, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif

  state_t state;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic             sum_v;
  logic [WIDTH-1:0] bin_res;
  logic             bin_c;
  logic             upd_c;
  logic             upd_v;
  logic             take_bcd;

  // Binary datapath straight from the operand latches; SUB is a + ~b + cin.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b_in : b_in;
    sum_ext = {1'b0, a_in} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum_v   = (a_in[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a_in[WIDTH-1]);
    bin_res = sum_ext[WIDTH-1:0];
    bin_c   = sum_ext[WIDTH];
    upd_c   = 1'b1;
    upd_v   = 1'b1;
    case (op)
      OP_ADD, OP_SUB: ;
      OP_AND: begin
        bin_res = a_in & b_in;
        upd_c   = 1'b0;
        upd_v   = 1'b0;
      end
      OP_EOR: begin
        bin_res = a_in ^ b_in;
        upd_c   = 1'b0;
        upd_v   = 1'b0;
      end
      OP_OR: begin
        bin_res = a_in | b_in;
        upd_c   = 1'b0;
        upd_v   = 1'b0;
      end
      OP_LSR: begin
        bin_res = {1'b0, a_in[WIDTH-1:1]};
        bin_c   = a_in[0];
        upd_v   = 1'b0;
      end
      OP_ROR: begin
        bin_res = {cin, a_in[WIDTH-1:1]};
        bin_c   = a_in[0];
        upd_v   = 1'b0;
      end
      OP_ROL: begin
        bin_res = {a_in[WIDTH-2:0], cin};
        bin_c   = a_in[WIDTH-1];
        upd_v   = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef ALU_BCD_EN
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] bcd_final;
  logic [CNTW-1:0]  cnt;
  logic             bcd_c;
  logic             bcd_sub;
  logic             v_hold;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_out;
  logic             nib_cin;
  logic             nib_sub;
  logic             nib_cout;
  logic [4:0]       nsum;
  logic [4:0]       ndiff;
  logic             last_nib;

  assign take_bcd = dec && ((op == OP_ADD) || (op == OP_SUB));
  assign last_nib = (cnt == CNTW'(NIBBLES - 1));

  // In IDLE the nibble corrector works off the raw inputs, so the capture edge
  // already settles nibble 0 and a whole word takes WIDTH/4 edges.
  always_comb begin
    if (state == S_IDLE) begin
      nib_a   = a_in[3:0];
      nib_b   = b_in[3:0];
      nib_cin = cin;
      nib_sub = (op == OP_SUB);
    end else begin
      nib_a   = opa[3:0];
      nib_b   = opb[3:0];
      nib_cin = bcd_c;
      nib_sub = bcd_sub;
    end
    nsum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, nib_cin};
    ndiff = {1'b0, nib_a} - {1'b0, nib_b} - {4'd0, ~nib_cin};
    if (nib_sub) begin
      nib_cout = ~ndiff[4];
      nib_out  = ndiff[4] ? (ndiff[3:0] - 4'd6) : ndiff[3:0];
    end else begin
      nib_cout = (nsum > 5'd9);
      nib_out  = nib_cout ? (nsum[3:0] + 4'd6) : nsum[3:0];
    end
    bcd_final = acc;
    bcd_final[{cnt, 2'b00} +: 4] = nib_out;
  end

  assign busy = (state == S_BCD) || ((state == S_IDLE) && start);
`else
  logic unused_dec;

  assign unused_dec = dec;
  assign take_bcd   = 1'b0;
  assign busy       = (state == S_IDLE) && start;
`endif

  // Sequencer: one-clock binary path, nibble-serial decimal path, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      neg      <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_BCD_EN
      opa      <= '0;
      opb      <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd_c    <= 1'b0;
      bcd_sub  <= 1'b0;
      v_hold   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && take_bcd) begin
`ifdef ALU_BCD_EN
            opa     <= a_in >> 4;
            opb     <= b_in >> 4;
            acc     <= bcd_final;
            bcd_c   <= nib_cout;
            bcd_sub <= (op == OP_SUB);
            v_hold  <= sum_v;
            cnt     <= CNTW'(1);
            state   <= S_BCD;
`endif
          end else if (start) begin
            result <= bin_res;
            zero   <= (bin_res == '0);
            neg    <= bin_res[WIDTH-1];
            if (upd_c) cout <= bin_c;
            if (upd_v) overflow <= sum_v;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
`ifdef ALU_BCD_EN
        S_BCD: begin
          if (last_nib) begin
            result   <= bcd_final;
            zero     <= (bcd_final == '0);
            neg      <= bcd_final[WIDTH-1];
            cout     <= nib_cout;
            overflow <= v_hold;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= S_DONE;
          end else begin
            acc   <= bcd_final;
            opa   <= opa >> 4;
            opb   <= opb >> 4;
            bcd_c <= nib_cout;
            cnt   <= cnt + CNTW'(1);
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign adl = adl_oe ? result : {WIDTH{1'bz}};
  assign sb  = sb_oe  ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_seq_bcd.sv
// tb_alu_seq_bcd: directed table-driven bench for alu_seq_bcd (WIDTH=8) plus WIDTH=16 sequences.
// Expectations follow the ALU_BCD_EN setting the bench is compiled with.
module tb_alu_seq_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start, dec, cin, adl_oe, sb_oe;
  logic [2:0] op;
  logic [7:0] a_in, b_in;
  logic       busy, done, cout, zero, overflow, neg;
  logic [7:0] result, adl, sb;

  logic        start16, dec16, cin16, adl_oe16, sb_oe16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, zero16, overflow16, neg16;
  logic [15:0] result16, adl16, sb16;

  int errors = 0;
  int checks = 0;

  alu_seq_bcd #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .dec(dec), .cin(cin),
    .a_in(a_in), .b_in(b_in), .adl_oe(adl_oe), .sb_oe(sb_oe),
    .busy(busy), .done(done), .result(result), .adl(adl), .sb(sb),
    .cout(cout), .zero(zero), .overflow(overflow), .neg(neg)
  );

  alu_seq_bcd #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .dec(dec16), .cin(cin16),
    .a_in(a16), .b_in(b16), .adl_oe(adl_oe16), .sb_oe(sb_oe16),
    .busy(busy16), .done(done16), .result(result16), .adl(adl16), .sb(sb16),
    .cout(cout16), .zero(zero16), .overflow(overflow16), .neg(neg16)
  );

  typedef struct {
    logic [2:0] op;
    logic       dec;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       v;
    logic       n;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] o, input logic d, input logic ci,
                              input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                              input logic c, input logic z, input logic v, input logic n,
                              input int lat);
    vec_t t;
    t.op = o; t.dec = d; t.cin = ci; t.a = a; t.b = b; t.res = r;
    t.c = c; t.z = z; t.v = v; t.n = n; t.lat = lat;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one cycle on the 8-bit DUT and count clocks until done (bounded).
  task automatic applyStimulus(input vec_t v, output int lat);
    @(negedge clk);
    op = v.op; dec = v.dec; cin = v.cin; a_in = v.a; b_in = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    start = 0; dec = 0; cin = 0; op = 3'd0; a_in = 8'h00; b_in = 8'h00; adl_oe = 0; sb_oe = 0;
    start16 = 0; dec16 = 0; cin16 = 0; op16 = 3'd0; a16 = 16'h0; b16 = 16'h0; adl_oe16 = 1; sb_oe16 = 1;

    //            op    dec  cin  a      b      res    C  Z  V  N  lat
    tbl.push_back(mk(3'd0, 0, 0, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 1));
`ifdef ALU_BCD_EN
    tbl.push_back(mk(3'd0, 1, 0, 8'h19, 8'h28, 8'h47, 0, 0, 0, 0, 2));
    tbl.push_back(mk(3'd0, 1, 0, 8'h99, 8'h01, 8'h00, 1, 1, 0, 0, 2));
    tbl.push_back(mk(3'd1, 1, 1, 8'h50, 8'h01, 8'h49, 1, 0, 0, 0, 2));
    tbl.push_back(mk(3'd1, 1, 1, 8'h00, 8'h01, 8'h99, 0, 0, 0, 1, 2));
    tbl.push_back(mk(3'd0, 1, 0, 8'h0F, 8'h01, 8'h16, 0, 0, 0, 0, 2));
`else
    tbl.push_back(mk(3'd0, 1, 0, 8'h19, 8'h28, 8'h41, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'd0, 1, 0, 8'h99, 8'h01, 8'h9A, 0, 0, 0, 1, 1));
    tbl.push_back(mk(3'd1, 1, 1, 8'h50, 8'h01, 8'h4F, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'd1, 1, 1, 8'h00, 8'h01, 8'hFF, 0, 0, 0, 1, 1));
    tbl.push_back(mk(3'd0, 1, 0, 8'h0F, 8'h01, 8'h10, 0, 0, 0, 0, 1));
`endif
    tbl.push_back(mk(3'd1, 0, 1, 8'h80, 8'h01, 8'h7F, 1, 0, 1, 0, 1));
    tbl.push_back(mk(3'd2, 0, 0, 8'hF0, 8'h3C, 8'h30, 1, 0, 1, 0, 1));
    tbl.push_back(mk(3'd3, 0, 0, 8'hFF, 8'hFF, 8'h00, 1, 1, 1, 0, 1));
    tbl.push_back(mk(3'd4, 0, 0, 8'h0A, 8'h50, 8'h5A, 1, 0, 1, 0, 1));
    tbl.push_back(mk(3'd6, 0, 1, 8'h01, 8'hAA, 8'h80, 1, 0, 1, 1, 1));
    tbl.push_back(mk(3'd7, 0, 0, 8'h80, 8'h00, 8'h00, 1, 1, 1, 0, 1));
    tbl.push_back(mk(3'd5, 0, 1, 8'h82, 8'hFF, 8'h41, 0, 0, 1, 0, 1));
    tbl.push_back(mk(3'd2, 1, 0, 8'h0F, 8'h05, 8'h05, 0, 0, 1, 0, 1));
    tbl.push_back(mk(3'd0, 0, 1, 8'h7F, 8'h80, 8'h00, 1, 1, 0, 0, 1));
    tbl.push_back(mk(3'd0, 0, 1, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0, 1));

    repeat (2) @(negedge clk);
    checkOutput("reset result", result, 8'h00);
    checkOutput("reset flags", {cout, zero, overflow, neg}, 4'b0000);
    checkOutput("reset busy/done", {busy, done}, 2'b00);
    checkOutput("reset result16", result16, 16'h0000);
    reset = 1'b0;

    foreach (tbl[i]) begin
      applyStimulus(tbl[i], lat);
      checkOutput($sformatf("v%0d latency", i), lat, tbl[i].lat);
      checkOutput($sformatf("v%0d result", i), result, tbl[i].res);
      checkOutput($sformatf("v%0d C", i), cout, tbl[i].c);
      checkOutput($sformatf("v%0d Z", i), zero, tbl[i].z);
      checkOutput($sformatf("v%0d V", i), overflow, tbl[i].v);
      checkOutput($sformatf("v%0d N", i), neg, tbl[i].n);
    end

    // Bus drivers: last result is 0x03.
    @(negedge clk);
    adl_oe = 0; sb_oe = 0;
    #1;
    checks++;
    if (adl === 8'h03) begin errors++; $display("[TB] FAIL adl released: got %0h, expected not driven", adl); end
    checks++;
    if (sb === 8'h03) begin errors++; $display("[TB] FAIL sb released: got %0h, expected not driven", sb); end
    adl_oe = 1;
    #1;
    checkOutput("adl driven", adl, 8'h03);
    checks++;
    if (sb === 8'h03) begin errors++; $display("[TB] FAIL sb still released: got %0h, expected not driven", sb); end
    sb_oe = 1;
    #1;
    checkOutput("adl+sb adl", adl, 8'h03);
    checkOutput("adl+sb sb", sb, 8'h03);

`ifdef ALU_BCD_EN
    // WIDTH=16 decimal add; a second start mid-sequence must be dropped.
    @(negedge clk);
    op16 = 3'd0; dec16 = 1; cin16 = 0; a16 = 16'h9999; b16 = 16'h0001; start16 = 1;
    @(negedge clk);
    start16 = 0;
    checkOutput("w16 c1 busy/done", {busy16, done16}, 2'b10);
    @(negedge clk);
    checkOutput("w16 c2 busy/done", {busy16, done16}, 2'b10);
    op16 = 3'd4; dec16 = 0; a16 = 16'h1234; b16 = 16'h4321; start16 = 1;
    @(negedge clk);
    start16 = 0;
    checkOutput("w16 c3 busy/done", {busy16, done16}, 2'b10);
    @(negedge clk);
    checkOutput("w16 c4 done", done16, 1'b1);
    checkOutput("w16 result", result16, 16'h0000);
    checkOutput("w16 C/Z", {cout16, zero16}, 2'b11);
    checkOutput("w16 buses", {adl16, sb16}, 32'h0000_0000);
    repeat (2) begin
      @(negedge clk);
      checkOutput("w16 no queued op", {done16, result16}, 17'h00000);
    end
`else
    @(negedge clk);
    op16 = 3'd0; dec16 = 1; cin16 = 0; a16 = 16'h9999; b16 = 16'h0001; start16 = 1;
    @(negedge clk);
    start16 = 0;
    checkOutput("w16 done", done16, 1'b1);
    checkOutput("w16 result", result16, 16'h999A);
    checkOutput("w16 C/N", {cout16, neg16}, 2'b01);
    checkOutput("w16 buses", {adl16, sb16}, 32'h999A_999A);
`endif

    // Reset during an in-flight decimal add.
    @(negedge clk);
    op = 3'd0; dec = 1; cin = 0; a_in = 8'h19; b_in = 8'h28; start = 1;
    @(negedge clk);
    start = 0;
`ifdef ALU_BCD_EN
    checkOutput("pre-reset busy", busy, 1'b1);
`endif
    reset = 1;
    @(negedge clk);
    checkOutput("midop reset result", result, 8'h00);
    checkOutput("midop reset flags", {cout, zero, overflow, neg}, 4'b0000);
    checkOutput("midop reset busy/done", {busy, done}, 2'b00);
    checkOutput("midop reset adl", adl, 8'h00);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post-reset no done", done, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_bcd.md
Name: alu_seq_bcd

Overview:
- Parametrised, handshaked successor to the 8-bit CPU ALU.
- Binary ops complete in one cycle. Decimal (BCD) add/subtract runs as a multi-cycle sequencer that corrects one nibble per clock, for any WIDTH.
- The result is registered and driven onto the tri-state internal buses adl/sb under output-enable control.
- Sits in the datapath between the A/B input latches and the adl/sb buses; the control unit drives start/op.

Parameters:
WIDTH, 8, operand/result width; must be a multiple of 4 and at least 8.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  accept operands/op this cycle (ignored while busy)
op  in  3  0 ADD, 1 SUB, 2 AND, 3 EOR, 4 OR, 5 LSR, 6 ROR, 7 ROL
dec  in  1  decimal mode, sampled with start; affects ADD/SUB only
cin  in  1  carry in (SUB: 1 = no borrow)
a_in  in  WIDTH  operand A
b_in  in  WIDTH  operand B
adl_oe  in  1  drive result onto adl
sb_oe  in  1  drive result onto sb
busy  out  1  operation in progress
done  out  1  one-cycle pulse when result/flags update
result  out  WIDTH  registered result
adl  out  WIDTH  result when adl_oe, else high-Z
sb  out  WIDTH  result when sb_oe, else high-Z
cout  out  1  carry flag (registered)
zero  out  1  result == 0 (registered)
overflow  out  1  signed overflow (registered)
neg  out  1  result MSB (registered)

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE; result, cout, zero, overflow, neg, busy, done all 0. Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, BCD, DONE.
- IDLE, no start: outputs hold their previous values.
- IDLE with start=1: a, b, op, dec and cin are captured.
  - Binary op, or dec=1 with op not ADD/SUB: the result is computed and registered at the next edge. Go to DONE: done=1 for that cycle, busy=1 only during the capture cycle. Latency is 1 clock.
  - Decimal ADD/SUB: go to BCD with nibble index 0, busy=1.
- BCD: one nibble per cycle, LSB nibble first; the carry/borrow chain is held in an internal register.
  - ADD: s = a_n + b_n + c. If s > 9: s = s + 6, c = 1; else c = 0. Keep 4 bits.
  - SUB: d = a_n - b_n - (1 - c). If d < 0: d = d - 6, c = 0; else c = 1. Keep 4 bits.
  - After nibble WIDTH/4 - 1, write the assembled result and flags and go to DONE.
  - Total latency is WIDTH/4 clocks from start to done.
- Invalid BCD digits (>9) are processed with the same formula, modulo 16; no error is flagged.
- DONE: done=1 for exactly one cycle, then return to IDLE. start is accepted again in the cycle after DONE.
- start while busy or in DONE: ignored and not queued.
- Arithmetic: ADD = a + b + cin; SUB = a + ~b + cin.
  - cout = carry out of the MSB.
  - overflow = signed overflow of that binary operation. In decimal mode, V is the binary-computed V of the same operands.
- Logic ops (AND/EOR/OR): cout and overflow are unchanged.
- Shifts (overflow unchanged):
  - LSR: result = a >> 1, msb = 0, cout = a[0].
  - ROR: msb = cin, cout = a[0].
  - ROL: lsb = cin, cout = a[WIDTH-1].
  - b_in is ignored.
- zero and neg are always computed from the final registered result.
- adl/sb are combinational from result and the output enables; both may be enabled at the same time.

Optional Feature:
- Macro ALU_BCD_EN.
- Defined: decimal ADD/SUB sequencer as described.
- Undefined: the BCD state and logic are not built; dec is ignored; ADD/SUB always take the 1-cycle binary path.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 cin=0 dec=0 -> done 1 clk after start; result 0x80, V=1, N=1, C=0, Z=0.
- WIDTH=8, dec=1 ADD 0x19+0x28 cin=0 -> 0x47, C=0, done 2 clks after start. Then 0x99+0x01 -> 0x00, C=1, Z=1.
- WIDTH=8, dec=1 SUB 0x50-0x01 cin=1 -> 0x49, C=1. Then 0x00-0x01 cin=1 -> 0x99, C=0, N=1.
- WIDTH=8, ROR a=0x01 cin=1 -> 0x80, C=1. ROL a=0x80 cin=0 -> 0x00, C=1, Z=1. AND leaves the prior C/V unchanged.
- WIDTH=16, dec=1 ADD 0x9999+0x0001 -> 0x0000, C=1, done 4 clks after start. A start pulsed at cycle 2 is ignored, and busy stays high throughout.
- reset asserted during the BCD state -> next cycle all outputs 0, busy=0, no done pulse. With adl_oe=0 and sb_oe=0, adl and sb are high-Z; with adl_oe=1, adl equals result.
